// File: rtl/edge_frame_capture.sv
// One-shot raster frame capture into a write-only frame-buffer port.
// Define CAPTURE_BINARIZE_EN to threshold pixels to all-ones / zero.
module edge_frame_capture #(
  parameter int WIDTH  = 8,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = $clog2(H_RES*V_RES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic              i_de,
  input  logic [WIDTH-1:0]  i_data,
  input  logic              i_start,
  input  logic [WIDTH-1:0]  i_threshold,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [WIDTH-1:0]  o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_frame_err
);

  localparam int XW = $clog2(H_RES+1);
  localparam int YW = $clog2(V_RES+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic              r_vsync_q;
  logic              r_de_q;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_vs_rise;
  logic              w_de_fall;
  logic              w_x_ok;
  logic              w_last_y;
  logic              w_last_px;
  logic              w_end;
  logic [WIDTH-1:0]  w_pix;
  logic [ADDR_W-1:0] w_gap;
  logic              w_unused;

  assign w_vs_rise = i_vsync & ~r_vsync_q;
  assign w_de_fall = ~i_de & r_de_q;
  assign w_x_ok    = r_x < XW'(H_RES);
  assign w_last_y  = r_y == YW'(V_RES-1);
  assign w_last_px = i_de & w_last_y
                   & (r_x == XW'(H_RES-1));
  // Frame completes normally even if vsync
  // rises on the very last pixel or de fall.
  assign w_end     = w_last_px
                   | (w_de_fall & w_last_y);
  assign w_gap     = ADDR_W'(H_RES)
                   - ADDR_W'(r_x);

`ifdef CAPTURE_BINARIZE_EN
  logic [WIDTH-1:0] r_thr;
  assign w_pix    = (i_data >= r_thr)
                  ? {WIDTH{1'b1}} : '0;
  assign w_unused = i_hsync;
`else
  assign w_pix    = i_data;
  assign w_unused = i_hsync ^ (^i_threshold);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_vsync_q <= 1'b0;
      r_de_q    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef CAPTURE_BINARIZE_EN
      r_thr     <= '0;
`endif
    end else begin
      r_vsync_q <= i_vsync;
      r_de_q    <= i_de;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        S_ARM: begin
          r_x    <= '0;
          r_y    <= '0;
          r_addr <= '0;
          if (w_vs_rise) begin
            r_state <= S_CAP;
`ifdef CAPTURE_BINARIZE_EN
            r_thr   <= i_threshold;
`endif
          end
        end
        S_CAP: begin
          if (w_vs_rise && !w_end) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            if (i_de) begin
              if (w_x_ok) begin
                r_we    <= 1'b1;
                r_waddr <= r_addr;
                r_wdata <= w_pix;
                r_addr  <= r_addr + ADDR_W'(1);
                r_x     <= r_x + XW'(1);
              end else begin
                r_err <= 1'b1;
              end
            end else if (w_de_fall) begin
              r_x <= '0;
              r_y <= r_y + YW'(1);
              if (w_x_ok) begin
                r_addr <= r_addr + w_gap;
                r_err  <= 1'b1;
              end
            end
            if (w_end) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_we        = r_we;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_frame_err = r_err;

endmodule
